// File: rtl/fifo_wptr_full_if.sv
// Write-side bundle of an async FIFO: producer request, synchronised read
// pointer in, and RAM address / Gray pointer / status flags out.
interface fifo_wptr_full_if #(
    parameter int ADD_SIZE = 3
);
    logic                w_en;
    logic                ovf_clr;
    logic [ADD_SIZE:0]   rq2_rptr;
    logic [ADD_SIZE-1:0] w_add;
    logic [ADD_SIZE:0]   w_ptr;
    logic                w_accept;
    logic                w_full;
    logic                w_almost_full;
    logic [ADD_SIZE:0]   w_level;
    logic                w_overflow;

    modport master (
        output w_en, ovf_clr, rq2_rptr,
        input  w_add, w_ptr, w_accept, w_full, w_almost_full, w_level, w_overflow
    );

    modport slave (
        input  w_en, ovf_clr, rq2_rptr,
        output w_add, w_ptr, w_accept, w_full, w_almost_full, w_level, w_overflow
    );
endinterface

// File: rtl/fifo_wptr_full.sv
// Async FIFO write-pointer and full-flag logic in the write clock domain.
// Flags are registered from the next pointer value, so they track accepts with no extra lag.
module fifo_wptr_full #(
    parameter int ADD_SIZE = 3,
    parameter int AF_LEVEL = 6
) (
    input  logic              w_clk,
    input  logic              rst,
    fifo_wptr_full_if.slave   bus
);

    localparam logic [ADD_SIZE:0] AF_THR    = (ADD_SIZE + 1)'(AF_LEVEL);
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    localparam logic [ADD_SIZE:0] FULL_MASK = {2'b11, {(ADD_SIZE - 1){1'b0}}};

    function automatic logic [ADD_SIZE:0] bin2gray(input logic [ADD_SIZE:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADD_SIZE:0] gray2bin(input logic [ADD_SIZE:0] g);
        logic [ADD_SIZE:0] b;
        b           = '0;
        b[ADD_SIZE] = g[ADD_SIZE];
        for (int i = ADD_SIZE - 1; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADD_SIZE:0] r_bin;
    logic [ADD_SIZE:0] r_ptr;
    logic              r_full;
    logic              r_af;
    logic [ADD_SIZE:0] r_level;
    logic              r_ovf;

    logic              w_acc;
    logic [ADD_SIZE:0] w_bin_next;
    logic [ADD_SIZE:0] w_gray_next;
    logic [ADD_SIZE:0] w_rbin;
    logic [ADD_SIZE:0] w_level_next;
    logic              w_full_next;
    logic              w_af_next;
    logic              w_ovf_next;

    // Reset also gates the RAM write so nothing lands in storage during reset.
    always_comb begin
        w_acc        = bus.w_en & ~r_full & ~rst;
        w_bin_next   = r_bin + {{ADD_SIZE{1'b0}}, w_acc};
        w_gray_next  = bin2gray(w_bin_next);
        w_rbin       = gray2bin(bus.rq2_rptr);
        w_level_next = w_bin_next - w_rbin;
        w_full_next  = (w_gray_next == (bus.rq2_rptr ^ FULL_MASK));
        w_af_next    = (w_level_next >= AF_THR);
        w_ovf_next   = r_ovf;
        if (bus.w_en && r_full) begin
            w_ovf_next = 1'b1;
        end else if (bus.ovf_clr) begin
            w_ovf_next = 1'b0;
        end
    end

    always_ff @(posedge w_clk) begin
        if (rst) begin
            r_bin   <= '0;
            r_ptr   <= '0;
            r_full  <= 1'b0;
            r_af    <= 1'b0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_bin   <= w_bin_next;
            r_ptr   <= w_gray_next;
            r_full  <= w_full_next;
            r_af    <= w_af_next;
            r_level <= w_level_next;
            r_ovf   <= w_ovf_next;
        end
    end

    assign bus.w_add         = r_bin[ADD_SIZE-1:0];
    assign bus.w_ptr         = r_ptr;
    assign bus.w_accept      = w_acc;
    assign bus.w_full        = r_full;
    assign bus.w_almost_full = r_af;
    assign bus.w_level       = r_level;
    assign bus.w_overflow    = r_ovf;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: counting model checked every cycle plus literal pins.
module tb_fifo_wptr_full;
    localparam int A    = 3;
    localparam int DEP  = 8;
    localparam int MODP = 16;

    logic w_clk = 1'b0;
    logic rst   = 1'b1;
    int   rc    = 0;
    int   total = 0;
    int   bad   = 0;

    int m_wc = 0, m_lvl = 0;
    bit m_full = 0, m_af = 0, m_ovf = 0;

    fifo_wptr_full_if #(.ADD_SIZE(A)) bus();

    fifo_wptr_full #(.ADD_SIZE(A), .AF_LEVEL(6)) dut (
        .w_clk (w_clk),
        .rst   (rst),
        .bus   (bus.slave)
    );

    always #5 w_clk = ~w_clk;

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Model: occupancy is simply writes minus reads, modulo the pointer range.
    always @(posedge w_clk) begin
        if (rst) begin
            m_wc = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0;
        end else begin
            if (bus.w_en && m_full) m_ovf = 1;
            else if (bus.ovf_clr)   m_ovf = 0;
            if (bus.w_en && !m_full) m_wc = (m_wc + 1) % MODP;
            m_lvl  = (((m_wc - rc) % MODP) + MODP) % MODP;
            m_full = (m_lvl == DEP);
            m_af   = (m_lvl >= 6);
        end
    end

    always @(negedge w_clk) begin
        chk("add",    int'(bus.w_add),         m_wc % DEP);
        chk("ptr",    int'(bus.w_ptr),         gray(m_wc));
        chk("full",   int'(bus.w_full),        int'(m_full));
        chk("afull",  int'(bus.w_almost_full), int'(m_af));
        chk("level",  int'(bus.w_level),       m_lvl);
        chk("ovf",    int'(bus.w_overflow),    int'(m_ovf));
        chk("accept", int'(bus.w_accept),      int'(bus.w_en && !m_full && !rst));
    end

    task automatic cyc(input bit en, input bit clr, input bit r, input int rcnt);
        bus.w_en     = en;
        bus.ovf_clr  = clr;
        rst          = r;
        rc           = rcnt;
        bus.rq2_rptr = 4'(gray(rcnt));
        @(posedge w_clk);
        @(negedge w_clk);
        #1;
    endtask

    initial begin
        bus.w_en = 1'b0; bus.ovf_clr = 1'b0; bus.rq2_rptr = '0;

        // Reset with a write request pending
        cyc(1, 0, 1, 0);
        chk("lit_rst_accept", int'(bus.w_accept), 0);
        chk("lit_rst_ptr",    int'(bus.w_ptr),    0);
        chk("lit_rst_full",   int'(bus.w_full),   0);
        chk("lit_rst_level",  int'(bus.w_level),  0);

        // Fill with no reads
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 0, 0, 0);
            if (i == 5) chk("lit_fill5_af", int'(bus.w_almost_full), 0);
            if (i == 6) begin
                chk("lit_fill6_af",    int'(bus.w_almost_full), 1);
                chk("lit_fill6_level", int'(bus.w_level),       6);
            end
        end
        chk("lit_full_ptr",   int'(bus.w_ptr),   4'b1100);
        chk("lit_full_level", int'(bus.w_level), 8);
        chk("lit_full_flag",  int'(bus.w_full),  1);
        chk("lit_full_add",   int'(bus.w_add),   0);

        // Overflow: sticky, cleared only by ovf_clr, set beats clear
        cyc(1, 0, 0, 0);
        chk("lit_ovf_accept", int'(bus.w_accept),   0);
        chk("lit_ovf_ptr",    int'(bus.w_ptr),      4'b1100);
        chk("lit_ovf_set",    int'(bus.w_overflow), 1);
        cyc(0, 0, 0, 0);
        chk("lit_ovf_hold",   int'(bus.w_overflow), 1);
        cyc(0, 1, 0, 0);
        chk("lit_ovf_clr",    int'(bus.w_overflow), 0);
        cyc(1, 1, 0, 0);
        chk("lit_ovf_setwin", int'(bus.w_overflow), 1);

        // Drain: reader advanced to 3
        cyc(0, 0, 0, 3);
        chk("lit_drain_full",  int'(bus.w_full),        0);
        chk("lit_drain_level", int'(bus.w_level),       5);
        chk("lit_drain_af",    int'(bus.w_almost_full), 0);
        chk("lit_drain_ovf",   int'(bus.w_overflow),    1);

        // Mid-run reset, then first write
        cyc(0, 0, 1, 0);
        chk("lit_mrst_level", int'(bus.w_level),    0);
        chk("lit_mrst_ovf",   int'(bus.w_overflow), 0);
        chk("lit_mrst_ptr",   int'(bus.w_ptr),      0);
        cyc(1, 0, 0, 0);
        chk("lit_mrst_add1",  int'(bus.w_add),      1);
        chk("lit_mrst_ptr1",  int'(bus.w_ptr),      4'b0001);

        // Wrap: 16 writes with the reader trailing
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 0, (((1 + i) % MODP) + MODP - 1) % MODP);
            chk("lit_wrap_level", int'(bus.w_level), 2);
            if (i == 13) begin
                chk("lit_wrap_ptr15", int'(bus.w_ptr), 4'b1000);
                chk("lit_wrap_add7",  int'(bus.w_add), 7);
            end
            if (i == 14) begin
                chk("lit_wrap_ptr0",  int'(bus.w_ptr), 4'b0000);
                chk("lit_wrap_add0",  int'(bus.w_add), 0);
            end
        end

        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_wptr_full.md
FIFO_WPTR_FULL -- requirements
Module: fifo_wptr_full

Interface
REQ-001 Parameter ADD_SIZE, default 3: address width; FIFO depth is 2^ADD_SIZE entries.
REQ-002 Parameter AF_LEVEL, default 6: occupancy at or above which w_almost_full asserts; legal range 1..2^ADD_SIZE.
REQ-003 w_clk  input  1  sole write-domain clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 w_en  input  1  write request from producer.
REQ-006 ovf_clr  input  1  clears sticky overflow flag.
REQ-007 rq2_rptr  input  ADD_SIZE+1  Gray-coded read pointer, already synchronised into w_clk domain.
REQ-008 w_add  output  ADD_SIZE  binary write address to storage RAM.
REQ-009 w_ptr  output  ADD_SIZE+1  registered Gray-coded write pointer, for crossing to read domain.
REQ-010 w_accept  output  1  combinational RAM write enable.
REQ-011 w_full  output  1  registered full flag.
REQ-012 w_almost_full  output  1  registered almost-full flag.
REQ-013 w_level  output  ADD_SIZE+1  registered occupancy as seen from write side, range 0..2^ADD_SIZE.
REQ-014 w_overflow  output  1  sticky flag: write attempted while full.

Function
REQ-015 Internal binary pointer wbin, ADD_SIZE+1 bits; w_add = wbin[ADD_SIZE-1:0]; w_ptr = Gray(wbin), held in its own register, never derived combinationally at the output.
REQ-016 w_accept = w_en AND NOT w_full; same cycle, no latency.
REQ-017 wbin_next = wbin + w_accept, modulo 2^(ADD_SIZE+1); wraps from all-ones to 0 with no special handling.
REQ-018 Gray conversion: g = b XOR (b >> 1).
REQ-019 w_full register loads (Gray(wbin_next) == {~rq2_rptr[ADD_SIZE:ADD_SIZE-1], rq2_rptr[ADD_SIZE-2:0]}) each cycle.
REQ-020 rbin = Gray-to-binary(rq2_rptr), computed combinationally by prefix XOR from the MSB.
REQ-021 w_level register loads (wbin_next - rbin) modulo 2^(ADD_SIZE+1).
REQ-022 w_almost_full register loads (level_next >= AF_LEVEL), where level_next is the value loaded into w_level.
REQ-023 Flags therefore reflect the accept in the current cycle one edge later; a read seen through rq2_rptr deasserts full or almost-full on the next edge, which is pessimistic and safe.
REQ-024 When w_en is high while w_full is high: no accept, and wbin, w_add and w_ptr hold.
REQ-025 w_overflow sets on any edge where w_en AND w_full is true.
REQ-026 w_overflow clears on an edge where ovf_clr is high; if set and clear coincide, set wins.
REQ-027 Unaccepted cycles (w_en low) leave all pointers unchanged; flags still update from rq2_rptr.

Reset
REQ-028 rst high at a w_clk rising edge forces wbin=0, w_ptr=0, w_full=0, w_almost_full=0, w_level=0, w_overflow=0; w_add reads 0.
REQ-029 rst overrides w_en and ovf_clr in the same cycle; no write is accepted while rst is high.
REQ-030 Reset mid-operation discards all state immediately; the read side must be reset concurrently.

Verification (ADD_SIZE=3, AF_LEVEL=6)
REQ-031 Reset: rst=1 for one edge with w_en=1 -> all outputs 0, w_accept=0 while w_full=0 only after rst drops; w_ptr=4'b0000.
REQ-032 Fill: rq2_rptr=0, w_en=1 for 8 edges -> w_almost_full=1 after edge 6 (w_level=6); after edge 8 w_ptr=4'b1100, w_level=8, w_full=1, w_add=0.
REQ-033 Overflow: keep w_en=1 while full -> w_accept=0, w_ptr holds 4'b1100, w_overflow=1 after next edge; it stays 1 until ovf_clr=1 with w_en=0, then 0.
REQ-034 Drain: from full, set rq2_rptr=4'b0010 (Gray 3) -> next edge w_full=0, w_level=5, w_almost_full=0.
REQ-035 Wrap: 16 accepted writes with rq2_rptr tracking writes 2 behind -> w_ptr steps 4'b1000 (Gray 15) to 4'b0000, w_add 7->0, w_full never asserts, w_level constant 2.
REQ-036 Mid-run reset: w_level=5, w_overflow=1, assert rst for one edge -> all outputs 0 on that edge; next w_en=1 edge gives w_add=1, w_ptr=4'b0001.
